// File: rtl/audio_pkg.sv
// Shared I2S-style audio constants: default word width, receiver state encoding, channel polarity.
package audio_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam logic        WS_LEFT    = 1'b0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLeft  = 2'd1,
    StRight = 2'd2
  } state_t;

endpackage

// File: rtl/audio_receiver_bit_sync.sv
// Multi-flop synchronizer for one asynchronous bit, plus a one-clk rising-edge strobe.
module bit_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= (r_sync << 1) | SYNC_STAGES'(i_d);
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;

endmodule

// File: rtl/audio_receiver.sv
// Left-justified serial audio receiver: ws edge marks the MSB; pairs a left word with the next right.
module audio_receiver
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              au_bck,
  input  logic              au_ws,
  input  logic              au_data,
  output logic [DATA_W-1:0] au_left,
  output logic [DATA_W-1:0] au_right,
  output logic              sample_valid,
  output logic              frame_err,
  output logic              locked
);

  localparam int unsigned          CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DATA_W);

  logic                   w_bck_q, w_rise, w_ws, w_data;
  logic [SYNC_STAGES-1:0] r_ws_sync, r_data_sync;

  bit_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (au_bck),
    .o_q   (w_bck_q),
    .o_rise(w_rise)
  );

  // Same depth as the bck path so ws/data line up with the detected edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ws_sync   <= '0;
      r_data_sync <= '0;
    end else begin
      r_ws_sync   <= (r_ws_sync << 1) | SYNC_STAGES'(au_ws);
      r_data_sync <= (r_data_sync << 1) | SYNC_STAGES'(au_data);
    end
  end

  assign w_ws   = r_ws_sync[SYNC_STAGES-1];
  assign w_data = r_data_sync[SYNC_STAGES-1];

  state_t            r_state, w_state_nxt;
  logic              r_ws_prev, r_left_ok;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt, r_left_hold;
  logic [DATA_W-1:0] r_au_left, r_au_right;
  logic              r_valid, r_err, r_locked;
  logic              w_new, w_start, w_take, w_err, w_done;

  always_comb begin
    w_new       = (w_ws != r_ws_prev);
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_take      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_new && (w_ws == WS_LEFT)) begin
          w_state_nxt = StLeft;
          w_start     = 1'b1;
        end
      end
      default: begin
        if (w_new) begin
          w_state_nxt = (w_ws == WS_LEFT) ? StLeft : StRight;
          w_start     = 1'b1;
          w_err       = (r_cnt < CNT_FULL);
        end else if (r_cnt < CNT_FULL) begin
          w_take = 1'b1;
        end
      end
    endcase
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    if (w_start) begin
      w_cnt_nxt   = CNT_W'(1);
      w_shift_nxt = DATA_W'(w_data);
    end else if (w_take) begin
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_shift_nxt = (r_shift << 1) | DATA_W'(w_data);
    end
    w_done = (w_start || w_take) && (w_cnt_nxt == CNT_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ws_prev   <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_left_hold <= '0;
      r_left_ok   <= 1'b0;
      r_au_left   <= '0;
      r_au_right  <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_rise) begin
        r_ws_prev <= w_ws;
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_shift   <= w_shift_nxt;
        if (w_err) begin
          r_err     <= 1'b1;
          r_left_ok <= 1'b0;
        end
        if (w_start && (w_state_nxt == StLeft)) begin
          r_left_ok <= 1'b0;
        end
        if (w_done) begin
          if (w_state_nxt == StLeft) begin
            r_left_hold <= w_shift_nxt;
            r_left_ok   <= 1'b1;
          end else if (r_left_ok && !w_err) begin
            r_au_left  <= r_left_hold;
            r_au_right <= w_shift_nxt;
            r_valid    <= 1'b1;
            r_locked   <= 1'b1;
          end
        end
      end
    end
  end

  assign au_left      = r_au_left;
  assign au_right     = r_au_right;
  assign sample_valid = r_valid;
  assign frame_err    = r_err;
  assign locked       = r_locked;

endmodule
